// File: rtl/dcache_inval_seq_pkg.sv
// dcache_inval_seq_pkg: shared L1 dcache geometry, invalidation FSM states and byte-enable helper
package dcache_inval_seq_pkg;
  localparam int DCACHE_NUM_WORDS = 256;
  localparam int DCACHE_SET_ASSOC = 8;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_BYTE_OFFSET = 4;
  localparam int DCACHE_MAX_WAYS = 32;
  typedef enum logic [1:0] {INV_IDLE, INV_WALK, INV_DONE} inval_state_e;
  // Widest possible expansion; callers cast down to 8*SET_ASSOC bits.
  function automatic logic [8*DCACHE_MAX_WAYS-1:0] way_mask_to_be(input logic [DCACHE_MAX_WAYS-1:0] mask);
    for (int i = 0; i < DCACHE_MAX_WAYS; i++) way_mask_to_be[8*i +: 8] = {8{mask[i]}};
  endfunction
endpackage

// File: rtl/dcache_inval_seq.sv
// dcache_inval_seq: walks every dcache set clearing valid/dirty of the selected ways
module dcache_inval_seq import dcache_inval_seq_pkg::*; #(
  parameter int NUM_WORDS = DCACHE_NUM_WORDS,
  parameter int SET_ASSOC = DCACHE_SET_ASSOC,
  parameter int INDEX_WIDTH = DCACHE_INDEX_WIDTH,
  parameter int BYTE_OFFSET = DCACHE_BYTE_OFFSET,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [SET_ASSOC-1:0]   way_mask_i,
  output logic [SET_ASSOC-1:0]   req_o,
  output logic [INDEX_WIDTH-1:0] addr_o,
  output logic                   we_o,
  output logic [8*SET_ASSOC-1:0] vldrty_be_o,
  output logic                   valid_o,
  output logic                   dirty_o,
  input  logic                   gnt_i,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  inval_state_e state_q, state_d;
  logic [SET_ASSOC-1:0] mask_q, mask_d;
  logic [IW-1:0] idx_q, idx_d;
  logic init_q, init_d;
  logic walk;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INV_IDLE;
      mask_q <= '0;
      idx_q <= '0;
      init_q <= INIT_ON_RESET;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      init_q <= init_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    idx_d = idx_q;
    init_d = init_q;
    case (state_q)
      INV_IDLE: begin
        if (init_q) begin
          state_d = INV_WALK;
          mask_d = '1;
          idx_d = '0;
          init_d = 1'b0;
        end else if (start_i) begin
          state_d = |way_mask_i ? INV_WALK : INV_DONE;
          mask_d = way_mask_i;
          idx_d = '0;
        end
      end
      INV_WALK: begin
        if (gnt_i) begin
          state_d = (idx_q == LAST) ? INV_DONE : INV_WALK;
          idx_d = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
        end
      end
      INV_DONE: state_d = INV_IDLE;
      default: state_d = INV_IDLE;
    endcase
  end
  // Outputs decode straight from registered state, so they hold steady while gnt_i is low.
  assign walk = (state_q == INV_WALK);
  assign req_o = walk ? mask_q : '0;
  assign we_o = walk;
  assign addr_o = walk ? INDEX_WIDTH'({idx_q, {BYTE_OFFSET{1'b0}}}) : '0;
  assign vldrty_be_o = walk ? (8*SET_ASSOC)'(way_mask_to_be(DCACHE_MAX_WAYS'(mask_q))) : '0;
  assign valid_o = 1'b0;
  assign dirty_o = 1'b0;
  assign busy_o = walk;
  assign done_o = (state_q == INV_DONE);
endmodule

// File: doc/dcache_inval_seq.md
Name: dcache_inval_seq

Overview:
- Sequencer that walks every set of the private L1 dcache and clears the valid and dirty bits of selected ways.
- Runs automatically after reset (cache init) and on command (full or per-way invalidation).
- Drives one requester port of the SRAM tag-compare/arbiter with a req/gnt handshake.
- Signals busy while walking and a single-cycle done on completion.

Parameters:
- NUM_WORDS, 256, number of sets (lines per way). Power of two, >= 2.
- SET_ASSOC, 8, number of ways.
- INDEX_WIDTH, 12, width of the arbiter address (set index plus byte offset).
- BYTE_OFFSET, 4, log2 of line size in bytes. Set index = addr[INDEX_WIDTH-1:BYTE_OFFSET].
- INIT_ON_RESET, 1, 1 = start a full all-ways walk automatically after reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle invalidate command. Ignored while busy_o=1.
- way_mask_i  in  SET_ASSOC  ways to invalidate. Sampled when start_i is accepted.
- req_o  out  SET_ASSOC  per-way SRAM request to the arbiter
- addr_o  out  INDEX_WIDTH  line-aligned address: set index << BYTE_OFFSET, low bits 0
- we_o  out  1  write enable. Always 1 while req_o is nonzero.
- vldrty_be_o  out  8*SET_ASSOC  valid/dirty SRAM byte enables. Byte i is all ones iff way i is selected.
- valid_o  out  1  write value for valid. Constant 0.
- dirty_o  out  1  write value for dirty. Constant 0.
- gnt_i  in  1  arbiter grant for the current request
- busy_o  out  1  walk in progress. Gates the cache controllers' stall.
- done_o  out  1  single-cycle pulse when a walk completes

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset values (while rst_i=1 and the cycle after): req_o=0, addr_o=0, we_o=0, vldrty_be_o=0, busy_o=0, done_o=0, index=0, mask register=0.
- States: IDLE, WALK, DONE.
- Reset exit:
  - INIT_ON_RESET=1: the first cycle after rst_i deasserts enters WALK with mask = all ones. busy_o=1 from that cycle.
  - INIT_ON_RESET=0: enters IDLE.
- IDLE:
  - start_i=1 with way_mask_i != 0: latch the mask, index=0, go to WALK. busy_o=1 next cycle.
  - start_i=1 with way_mask_i == 0: go to DONE with no SRAM requests. done_o=1 next cycle.
- WALK:
  - req_o=mask, we_o=1, addr_o={index, BYTE_OFFSET'b0}, vldrty_be_o built from the mask.
  - Request held stable until gnt_i=1. Outputs must not change while waiting.
  - On gnt_i=1 and index < NUM_WORDS-1: index++. The next set is requested in the following cycle, giving back-to-back requests at 1 set/cycle under continuous grant.
  - On gnt_i=1 and index == NUM_WORDS-1: req_o=0 and we_o=0 next cycle, go to DONE. The index never wraps past NUM_WORDS-1.
- DONE: done_o=1 and busy_o=0 for exactly one cycle, then IDLE. start_i in this cycle is ignored.
- start_i while busy: ignored; the latched mask is unchanged.
- Reset mid-walk: rst_i=1 aborts immediately; outputs take reset values next edge. With INIT_ON_RESET=1 the walk restarts from index 0 with all ways.
- Latency: a full walk under continuous grant takes NUM_WORDS WALK cycles plus 1 DONE cycle.
- Index counter width: log2(NUM_WORDS). addr_o bits above index are zero-extended if INDEX_WIDTH exceeds BYTE_OFFSET+log2(NUM_WORDS).
- gnt_i while req_o=0: ignored.

Decomposition:
- Shared cache package holds:
  - the state enum for IDLE/WALK/DONE
  - a function expanding a way mask to valid/dirty byte enables (8 bits per way), shared with the flush logic in the miss handler.
- No sub-module. The counter and FSM live in one module.
- Parameters default from the package values: DCACHE_NUM_WORDS, DCACHE_SET_ASSOC, DCACHE_INDEX_WIDTH, DCACHE_BYTE_OFFSET.

Test Plan:
- Reset walk, continuous grant: NUM_WORDS=4, SET_ASSOC=2, INIT_ON_RESET=1, gnt_i=1 -> req_o=2'b11 with addr_o 0x00, 0x10, 0x20, 0x30 on 4 consecutive cycles; done_o=1 on cycle 5; busy_o high for cycles 1-4.
- Grant stall: gnt_i low for 3 cycles at index 2 -> addr_o held at 0x20 and req_o stable for 4 cycles; total walk takes 7 cycles before DONE.
- Per-way invalidation: start_i with way_mask_i=2'b10 -> req_o=2'b10, vldrty_be_o=16'hFF00 for every set; way 0 valid/dirty in the SRAM model unchanged.
- Zero mask: start_i with way_mask_i=0 -> no req_o activity; done_o pulse on the next cycle.
- Start while busy: start_i with mask 2'b01 mid-walk -> ignored; walk completes with the original mask; exactly one done_o.
- Mid-walk reset: rst_i at index 2 -> req_o=0 next edge; after release, a fresh walk runs from addr_o=0x00 with all ways and ends with one done_o.
